// File: rtl/vga_segdac_pkg.sv
// vga_segdac_pkg: shared VGA timing constants, pattern selector encoding and DAC code width
package vga_segdac_pkg;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int HS_START = 656;
    localparam int HS_END   = 751;
    localparam int VS_START = 490;
    localparam int VS_END   = 491;
    localparam int CODE_W   = 12;

    typedef enum logic [1:0] {PAT_EXT, PAT_BARS, PAT_GRAD, PAT_XOR} pat_e;
endpackage

// File: rtl/segdac_therm_enc.sv
// segdac_therm_enc: 8-bit colour to 12-bit segmented code, each 2-bit digit becomes a 3-switch thermometer
module segdac_therm_enc
    import vga_segdac_pkg::*;
(
    input  logic [7:0]        value,
    output logic [CODE_W-1:0] code
);
    for (genvar i = 0; i < 4; i++) begin : g_seg
        assign code[3*i +: 3] = {value[2*i+1] & value[2*i], value[2*i+1], value[2*i+1] | value[2*i]};
    end
endmodule

// File: rtl/vga_segdac_driver.sv
// vga_segdac_driver: VGA timing counters, pixel source select and segmented DAC codes,
// with sync/de/R/G/B two registered stages behind hpos/vpos.
module vga_segdac_driver
    import vga_segdac_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        pattern_sel,
    input  logic [7:0]        ext_r,
    input  logic [7:0]        ext_g,
    input  logic [7:0]        ext_b,
    output logic [9:0]        hpos,
    output logic [9:0]        vpos,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [7:0]        frame,
    output logic [CODE_W-1:0] R,
    output logic [CODE_W-1:0] G,
    output logic [CODE_W-1:0] B
);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [6:0] BAR_LAST = 7'(H_ACTIVE / 8 - 1);

    logic              h_wrap, v_wrap;
    logic [6:0]        bar_cnt;
    logic [2:0]        bar_idx;
    pat_e              sel;
    logic [7:0]        xy, pix_r, pix_g, pix_b;
    logic              act1, hs1, vs1;
    logic [7:0]        r1, g1, b1;
    logic [CODE_W-1:0] enc_r, enc_g, enc_b;

    assign h_wrap = hpos == H_LAST;
    assign v_wrap = vpos == V_LAST;
    assign sel    = pat_e'(pattern_sel);
    assign xy     = hpos[7:0] ^ vpos[7:0];

    // bar_cnt/bar_idx track hpos so the bar index needs no divider
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hpos    <= '0;
            vpos    <= '0;
            frame   <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
        end else begin
            hpos    <= h_wrap ? '0 : hpos + 10'd1;
            vpos    <= h_wrap ? (v_wrap ? '0 : vpos + 10'd1) : vpos;
            frame   <= (h_wrap && v_wrap) ? frame + 8'd1 : frame;
            bar_cnt <= (h_wrap || bar_cnt == BAR_LAST) ? '0 : bar_cnt + 7'd1;
            bar_idx <= h_wrap ? '0 :
                       (bar_cnt == BAR_LAST && bar_idx != 3'd7) ? bar_idx + 3'd1 : bar_idx;
        end
    end

    always_comb begin
        {pix_r, pix_g, pix_b} = {ext_r, ext_g, ext_b};
        case (sel)
            PAT_BARS: {pix_r, pix_g, pix_b} = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
            PAT_GRAD: {pix_r, pix_g, pix_b} = {hpos[7:0], vpos[7:0], xy};
            PAT_XOR:  {pix_r, pix_g, pix_b} = {3{xy + frame}};
            default: ;
        endcase
    end

    segdac_therm_enc u_enc_r (.value(r1), .code(enc_r));
    segdac_therm_enc u_enc_g (.value(g1), .code(enc_g));
    segdac_therm_enc u_enc_b (.value(b1), .code(enc_b));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {act1, hs1, vs1} <= 3'b011;
            {r1, g1, b1}     <= '0;
            {de, hsync, vsync} <= 3'b011;
            {R, G, B}        <= '0;
        end else begin
            act1  <= hpos < H_VIS && vpos < V_VIS;
            hs1   <= !(hpos >= HS_FIRST && hpos <= HS_LAST);
            vs1   <= !(vpos >= VS_FIRST && vpos <= VS_LAST);
            {r1, g1, b1} <= {pix_r, pix_g, pix_b};
            de    <= act1;
            hsync <= hs1;
            vsync <= vs1;
            R     <= act1 ? enc_r : '0;
            G     <= act1 ? enc_g : '0;
            B     <= act1 ? enc_b : '0;
        end
    end
endmodule
